key_note_encoder: RTL and testbench



---
 rtl/piano_pkg.sv | 14 +
 rtl/key_debounce.sv | 59 +++++
 rtl/key_note_encoder.sv | 134 +++++++++++++
 tb/tb_key_note_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared types and defaults for the piano key front end.
package piano_pkg;

  localparam int NOTE_CODE_W       = 4;
  localparam int DEFAULT_IDLE_CODE = 15;

  typedef logic [NOTE_CODE_W-1:0] noteCode_t;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } keyState_e;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser plus whole-vector debounce: a new key pattern is
// accepted only after the synchronised vector has held still long enough.
module key_debounce #(
  parameter int N               = 7,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_i,
  output logic [N-1:0] stable_o
);

  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]     syncOne_q;
  logic [N-1:0]     syncTwo_q;
  logic [N-1:0]     cand_q;
  logic [N-1:0]     cand_d;
  logic [N-1:0]     stable_q;
  logic [N-1:0]     stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Any movement of the synchronised vector restarts the count; once the count saturates the candidate becomes the accepted pattern.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (syncTwo_q != cand_q) begin
      cand_d = syncTwo_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      syncOne_q <= '0;
      syncTwo_q <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
    end else begin
      syncOne_q <= key_i;
      syncTwo_q <= syncOne_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/key_note_encoder.sv
// Debounced key vector to note code encoder with press/release tracking
// and multi-key error reporting.
module key_note_encoder
  import piano_pkg::*;
#(
  parameter int N_KEYS          = 7,
  parameter int CODE_W          = NOTE_CODE_W,
  parameter int IDLE_CODE       = DEFAULT_IDLE_CODE,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int PRIORITY_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [CODE_W-1:0] code_out,
  output logic              key_down,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              multi_err
);

  localparam logic [CODE_W-1:0] IDLE_C = CODE_W'(IDLE_CODE);

  logic [N_KEYS-1:0] stableKeys;
  logic              encValid;
  logic [CODE_W-1:0] encCode;
  logic              encMulti;
  int                setCount;

  keyState_e         state_q;
  keyState_e         state_d;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic              press_q;
  logic              press_d;
  logic              release_q;
  logic              release_d;
  logic              multiErr_q;
  logic              multiErr_d;

  key_debounce #(
    .N               (N_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) uDebounce (
    .clk      (clk),
    .rst      (rst),
    .key_i    (key_in),
    .stable_o (stableKeys)
  );

  // Encode the accepted vector; scanning downwards leaves the lowest set key's code.
  always_comb begin
    encCode  = '0;
    setCount = 0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (stableKeys[i]) begin
        encCode  = CODE_W'(i + 1);
        setCount = setCount + 1;
      end
    end
    encValid = 1'b0;
    encMulti = 1'b0;
    if (setCount == 1) begin
      encValid = 1'b1;
    end else if (setCount > 1) begin
      if (PRIORITY_MODE == 0) begin
        encMulti = 1'b1;
      end else begin
        encValid = 1'b1;
      end
    end
  end

  // Press/release tracking; a direct change of note while held fires both strobes together.
  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    multiErr_d = encMulti;
    case (state_q)
      IDLE: begin
        if (encValid) begin
          code_d  = encCode;
          press_d = 1'b1;
          state_d = HELD;
        end else begin
          code_d = IDLE_C;
        end
      end
      HELD: begin
        if (encValid) begin
          if (encCode != code_q) begin
            code_d    = encCode;
            press_d   = 1'b1;
            release_d = 1'b1;
          end
        end else begin
          code_d    = IDLE_C;
          release_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        code_d  = IDLE_C;
        state_d = IDLE;
      end
    endcase
  end

  // Output and state registers; reset drops any held note silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      code_q     <= IDLE_C;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      multiErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      press_q    <= press_d;
      release_q  <= release_d;
      multiErr_q <= multiErr_d;
    end
  end

  assign code_out      = code_q;
  assign key_down      = (state_q == HELD);
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign multi_err     = multiErr_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// Bench for key_note_encoder: one instance per priority mode, a behavioural
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_key_note_encoder;

  localparam int NK   = 7;
  localparam int DB   = 4;
  localparam int HIST = DB + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NK-1:0]   keyIn = '0;
  logic [1:0][3:0] codeOut;
  logic [1:0]      keyDown;
  logic [1:0]      pressPulse;
  logic [1:0]      releasePulse;
  logic [1:0]      multiErr;

  int checkCount = 0;
  int passCount  = 0;

  // model state
  logic [NK-1:0] hist [HIST];
  logic [NK-1:0] mStable = '0;
  int            expCode  [2];
  int            expDown  [2];
  int            expPress [2];
  int            expRel   [2];
  int            expMulti [2];
  bit            modelReady = 1'b0;

  // window observation
  int cycIdx;
  int pressCnt [2];
  int relCnt   [2];
  int pressIdx [2];
  int relIdx   [2];
  int downDrop [2];
  int mPressIdx;

  key_note_encoder #(
    .N_KEYS(NK), .CODE_W(4), .IDLE_CODE(15), .DEBOUNCE_CYCLES(DB), .PRIORITY_MODE(0)
  ) dutStrict (
    .clk(clk), .rst(rst), .key_in(keyIn), .code_out(codeOut[0]), .key_down(keyDown[0]),
    .press_pulse(pressPulse[0]), .release_pulse(releasePulse[0]), .multi_err(multiErr[0])
  );

  key_note_encoder #(
    .N_KEYS(NK), .CODE_W(4), .IDLE_CODE(15), .DEBOUNCE_CYCLES(DB), .PRIORITY_MODE(1)
  ) dutPrio (
    .clk(clk), .rst(rst), .key_in(keyIn), .code_out(codeOut[1]), .key_down(keyDown[1]),
    .press_pulse(pressPulse[1]), .release_pulse(releasePulse[1]), .multi_err(multiErr[1])
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k);
    @(negedge clk);
    keyIn = k;
  endtask

  task automatic setReset(input logic r);
    @(negedge clk);
    rst = r;
  endtask

  task automatic clearWindow();
    cycIdx    = 0;
    mPressIdx = -1;
    for (int m = 0; m < 2; m++) begin
      pressCnt[m] = 0;
      relCnt[m]   = 0;
      pressIdx[m] = -1;
      relIdx[m]   = -1;
      downDrop[m] = 0;
    end
  endtask

  task automatic runCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (pressPulse[m] === 1'b1) begin
          pressCnt[m]++;
          if (pressIdx[m] < 0) pressIdx[m] = cycIdx;
        end
        if (releasePulse[m] === 1'b1) begin
          relCnt[m]++;
          if (relIdx[m] < 0) relIdx[m] = cycIdx;
        end
        if (keyDown[m] !== 1'b1) downDrop[m] = 1;
      end
      if (expPress[0] == 1 && mPressIdx < 0) mPressIdx = cycIdx;
      cycIdx++;
    end
  endtask

  // Behavioural model: a pattern is accepted once DB+1 consecutive samples
  // agree (accounting for the two sync stages); outputs follow one cycle later.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int h = 0; h < HIST; h++) hist[h] = '0;
        mStable = '0;
        for (int m = 0; m < 2; m++) begin
          expCode[m] = 15; expDown[m] = 0; expPress[m] = 0; expRel[m] = 0; expMulti[m] = 0;
        end
        modelReady = 1'b1;
      end else begin
        for (int m = 0; m < 2; m++) begin
          int ones;
          int low;
          int valid;
          ones  = $countones(mStable);
          low   = 0;
          for (int i = NK - 1; i >= 0; i--) if (mStable[i]) low = i + 1;
          valid = (ones == 1 || (ones > 1 && m == 1)) ? 1 : 0;
          expPress[m] = (valid == 1 && (expDown[m] == 0 || low != expCode[m])) ? 1 : 0;
          expRel[m]   = (expDown[m] == 1 && (valid == 0 || low != expCode[m])) ? 1 : 0;
          expDown[m]  = valid;
          expCode[m]  = (valid == 1) ? low : 15;
          expMulti[m] = (m == 0 && ones > 1) ? 1 : 0;
        end
        for (int h = HIST - 1; h > 0; h--) hist[h] = hist[h-1];
        hist[0] = keyIn;
        begin
          bit same;
          same = 1'b1;
          for (int h = 3; h < HIST; h++) if (hist[h] != hist[2]) same = 1'b0;
          if (same) mStable = hist[2];
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (modelReady) begin
        for (int m = 0; m < 2; m++) begin
          checkOutput($sformatf("model code m%0d", m), int'(codeOut[m]), expCode[m]);
          checkOutput($sformatf("model keyDown m%0d", m), int'(keyDown[m]), expDown[m]);
          checkOutput($sformatf("model press m%0d", m), int'(pressPulse[m]), expPress[m]);
          checkOutput($sformatf("model release m%0d", m), int'(releasePulse[m]), expRel[m]);
          checkOutput($sformatf("model multi m%0d", m), int'(multiErr[m]), expMulti[m]);
        end
      end
    end
  end

  initial begin
    // reset with keys idle
    clearWindow();
    runCycles(3);
    checkOutput("reset code", int'(codeOut[0]), 15);
    checkOutput("reset keyDown", int'(keyDown[0]), 0);
    checkOutput("reset multi", int'(multiErr[0]), 0);
    checkOutput("reset press", int'(pressPulse[0]), 0);
    checkOutput("reset release", int'(releasePulse[0]), 0);
    setReset(1'b0);
    clearWindow();
    runCycles(10);
    checkOutput("post reset presses", pressCnt[0] + pressCnt[1], 0);
    checkOutput("post reset releases", relCnt[0] + relCnt[1], 0);

    // single press and release of key 2
    clearWindow();
    applyStimulus(7'b0000100);
    runCycles(12);
    checkOutput("press index", pressIdx[0], 7);
    checkOutput("model press index", mPressIdx, 7);
    checkOutput("press count", pressCnt[0], 1);
    checkOutput("press code", int'(codeOut[0]), 3);
    checkOutput("model press code", expCode[0], 3);
    checkOutput("press keyDown", int'(keyDown[0]), 1);
    clearWindow();
    applyStimulus(7'b0000000);
    runCycles(12);
    checkOutput("release index", relIdx[0], 7);
    checkOutput("release count", relCnt[0], 1);
    checkOutput("release code", int'(codeOut[0]), 15);
    checkOutput("release keyDown", int'(keyDown[0]), 0);

    // short glitch must be filtered
    clearWindow();
    applyStimulus(7'b0000001);
    runCycles(3);
    applyStimulus(7'b0000000);
    runCycles(12);
    checkOutput("glitch presses", pressCnt[0], 0);
    checkOutput("glitch releases", relCnt[0], 0);
    checkOutput("glitch code", int'(codeOut[0]), 15);

    // legato from key 1 to key 6
    clearWindow();
    applyStimulus(7'b0000010);
    runCycles(12);
    checkOutput("legato first code", int'(codeOut[0]), 2);
    clearWindow();
    applyStimulus(7'b1000000);
    runCycles(12);
    checkOutput("legato press count", pressCnt[0], 1);
    checkOutput("legato release count", relCnt[0], 1);
    checkOutput("legato same cycle", relIdx[0], pressIdx[0]);
    checkOutput("legato press index", pressIdx[0], 7);
    checkOutput("legato keyDown drop", downDrop[0], 0);
    checkOutput("legato code", int'(codeOut[0]), 7);
    applyStimulus(7'b0000000);
    runCycles(12);

    // two keys together: strict mode flags, priority mode plays lowest
    clearWindow();
    applyStimulus(7'b0000011);
    runCycles(12);
    checkOutput("multi strict err", int'(multiErr[0]), 1);
    checkOutput("multi strict code", int'(codeOut[0]), 15);
    checkOutput("multi strict presses", pressCnt[0], 0);
    checkOutput("multi prio code", int'(codeOut[1]), 1);
    checkOutput("multi prio presses", pressCnt[1], 1);
    checkOutput("multi prio err", int'(multiErr[1]), 0);
    checkOutput("model multi err", expMulti[0], 1);
    clearWindow();
    applyStimulus(7'b0000000);
    runCycles(12);
    checkOutput("multi strict err clear", int'(multiErr[0]), 0);
    checkOutput("multi strict releases", relCnt[0], 0);
    checkOutput("multi prio releases", relCnt[1], 1);

    // reset while key 5 is held
    clearWindow();
    applyStimulus(7'b0100000);
    runCycles(12);
    checkOutput("hold code", int'(codeOut[0]), 6);
    clearWindow();
    setReset(1'b1);
    runCycles(2);
    checkOutput("mid reset releases", relCnt[0] + relCnt[1], 0);
    checkOutput("mid reset code", int'(codeOut[0]), 15);
    checkOutput("mid reset keyDown", int'(keyDown[0]), 0);
    setReset(1'b0);
    clearWindow();
    runCycles(12);
    checkOutput("after reset releases", relCnt[0], 0);
    checkOutput("after reset press index", pressIdx[0], 7);
    checkOutput("after reset press count", pressCnt[0], 1);
    checkOutput("after reset code", int'(codeOut[0]), 6);
    applyStimulus(7'b0000000);
    runCycles(12);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
